// File: rtl/fpgapu_audio_stream.sv
// APU sample back-end: IIR low-pass, fractional-rate decimation, width
// rescaling and a first-word-fall-through FIFO with sticky overflow.
module fpgapu_audio_stream #(
   parameter int CLOCK_FREQ  = 1_000_000,
   parameter int SAMPLE_RATE = 44_100,
   parameter int IN_WIDTH    = 9,
   parameter int OUT_WIDTH   = 8,
   parameter int LPF_SHIFT   = 0,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [IN_WIDTH-1:0]         i_sample,
   input  logic                        i_enable,
   output logic [OUT_WIDTH-1:0]        o_data,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [$clog2(FIFO_DEPTH):0] o_level,
   output logic                        o_overflow,
   input  logic                        i_clear_overflow
);
   localparam int YW    = IN_WIDTH + LPF_SHIFT;
   localparam int ACC_W = $clog2(CLOCK_FREQ + SAMPLE_RATE + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [ACC_W-1:0] C_RATE  = ACC_W'(SAMPLE_RATE);
   localparam logic [ACC_W-1:0] C_CLK   = ACC_W'(CLOCK_FREQ);
   localparam logic [AW:0]      C_DEPTH = (AW+1)'(FIFO_DEPTH);

   logic [YW-1:0]        r_y;
   logic [YW:0]          w_y_next;
   logic [IN_WIDTH-1:0]  w_f;
   logic [OUT_WIDTH-1:0] w_word;
   logic [ACC_W-1:0]     r_acc;
   logic [ACC_W-1:0]     w_acc_sum;
   logic                 w_tick;
   logic                 w_push;
   logic                 w_pop;
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [AW:0]          r_level;
   logic                 r_overflow;
   logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];

   // One extra bit keeps the subtract-then-add free of wrap; the result fits in YW bits.
   assign w_y_next = {1'b0, r_y} - ({1'b0, r_y} >> LPF_SHIFT) + (YW+1)'(i_sample);
   assign w_f      = IN_WIDTH'(r_y >> LPF_SHIFT);

   generate
      if (OUT_WIDTH <= IN_WIDTH) begin : g_narrow
         assign w_word = w_f[IN_WIDTH-1 -: OUT_WIDTH];
      end else begin : g_wide
         assign w_word = {w_f, {(OUT_WIDTH-IN_WIDTH){1'b0}}};
      end
   endgenerate

   assign w_acc_sum = r_acc + C_RATE;
   assign w_tick    = i_enable && (w_acc_sum >= C_CLK);

   assign o_valid    = (r_level != '0);
   assign w_pop      = o_valid && i_ready;
   assign w_push     = w_tick && ((r_level < C_DEPTH) || w_pop);
   assign o_level    = r_level;
   assign o_overflow = r_overflow;
   // Gating keeps stale memory off the bus while empty or in reset.
   assign o_data     = o_valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_y   <= '0;
         r_acc <= '0;
      end else if (i_enable) begin
         r_y   <= w_y_next[YW-1:0];
         r_acc <= w_tick ? (w_acc_sum - C_CLK) : w_acc_sum;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_word;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_tick && !w_push)  r_overflow <= 1'b1;
         else if (i_clear_overflow) r_overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fpgapu_audio_stream.sv
// Directed bench for fpgapu_audio_stream: passthrough instance plus an
// LPF_SHIFT=4 instance for the filter step response.
module tb_fpgapu_audio_stream;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] sample_a = '0, sample_b = '0;
   logic       en_a = 1'b0, en_b = 1'b0;
   logic       ready_a = 1'b0, ready_b = 1'b0;
   logic       clr_a = 1'b0, clr_b = 1'b0;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b, ovf_a, ovf_b;
   logic [4:0] level_a, level_b;

   int n_chk = 0, n_fail = 0;
   int acc_m = 0, ntick = 0, cyc = 0;
   logic [8:0] y_m = '0;
   logic [7:0] q[$];

   typedef struct { logic [8:0] s; logic [7:0] w; } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   fpgapu_audio_stream u_dut (
      .i_clk(clk), .i_rst(rst), .i_sample(sample_a), .i_enable(en_a),
      .o_data(data_a), .o_valid(valid_a), .i_ready(ready_a),
      .o_level(level_a), .o_overflow(ovf_a), .i_clear_overflow(clr_a));

   fpgapu_audio_stream #(.LPF_SHIFT(4)) u_lpf (
      .i_clk(clk), .i_rst(rst), .i_sample(sample_b), .i_enable(en_b),
      .o_data(data_b), .o_valid(valid_b), .i_ready(ready_b),
      .o_level(level_b), .o_overflow(ovf_b), .i_clear_overflow(clr_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q.delete();
      acc_m = 0; ntick = 0; y_m = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Reference behaviour of the passthrough instance for one clock.
   task automatic step_a();
      logic pop_m, tick_m;
      pop_m  = (q.size() > 0) && ready_a;
      tick_m = en_a && (acc_m + 44100 >= 1000000);
      if (pop_m) void'(q.pop_front());
      if (en_a) begin
         if (tick_m) begin
            ntick++;
            acc_m = acc_m + 44100 - 1000000;
            if (q.size() < 16) q.push_back(y_m[8:1]);
         end else begin
            acc_m = acc_m + 44100;
         end
         y_m = sample_a;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic run_until(input int n);
      int g = 0;
      while (ntick < n && g < 3000) begin
         sample_a = 9'(cyc * 37 + 5);
         step_a();
         g++;
      end
   endtask

   task automatic to_tick_cycle();
      int g = 0;
      while (!(acc_m + 44100 >= 1000000) && g < 100) begin
         sample_a = 9'(cyc * 37 + 5);
         step_a();
         g++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int hs, prev, npop;
      tbl[0] = '{9'h1A5, 8'hD2};
      tbl[1] = '{9'h000, 8'h00};
      tbl[2] = '{9'h1FF, 8'hFF};
      tbl[3] = '{9'h001, 8'h00};
      tbl[4] = '{9'h100, 8'h80};
      tbl[5] = '{9'h0FF, 8'h7F};

      // First tick timing and width conversion for a table of constant inputs.
      for (int i = 0; i < 6; i++) begin
         sample_a = tbl[i].s; en_a = 1'b1; ready_a = 1'b0;
         do_reset();
         repeat (22) @(posedge clk);
         #1;
         chk("first_tick_not_early", 32'(valid_a), 32'd0);
         @(posedge clk); #1;
         chk("first_tick_valid", 32'(valid_a), 32'd1);
         chk("first_tick_data", 32'(data_a), 32'(tbl[i].w));
         chk("first_tick_level", 32'(level_a), 32'd1);
      end

      // Asynchronous reset mid-cycle with 5 entries queued.
      en_a = 1'b1; ready_a = 1'b0;
      do_reset();
      run_until(5);
      chk("pre_reset_level", 32'(level_a), 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_level", 32'(level_a), 32'd0);
      chk("rst_overflow", 32'(ovf_a), 32'd0);
      chk("rst_data", 32'(data_a), 32'd0);

      // Rate: 20000 enabled cycles give exactly 882 ticks, then enable low.
      ready_a = 1'b1; sample_a = 9'h0AA;
      do_reset();
      hs = 0;
      for (int c = 1; c <= 20001; c++) begin
         en_a = (c <= 20000);
         @(posedge clk); #1;
         if (valid_a && ready_a) hs++;
      end
      chk("rate_handshakes", 32'(hs), 32'd882);
      chk("rate_overflow", 32'(ovf_a), 32'd0);
      hs = 0;
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk); #1;
         if (valid_a && ready_a) hs++;
      end
      chk("disabled_handshakes", 32'(hs), 32'd0);
      chk("disabled_level", 32'(level_a), 32'd0);

      // Filter step on the LPF_SHIFT=4 instance.
      en_a = 1'b0; ready_a = 1'b0;
      en_b = 1'b1; ready_b = 1'b1; sample_b = '0;
      do_reset();
      prev = -1; npop = 0;
      for (int c = 1; c <= 2000; c++) begin
         sample_b = (c >= 22) ? 9'h100 : 9'h000;
         @(posedge clk); #1;
         if (valid_b && ready_b) begin
            if (npop == 0) chk("lpf_first_f16", 32'(data_b), 32'h08);
            else chk("lpf_monotonic", 32'(int'(data_b) >= prev), 32'd1);
            chk("lpf_no_overshoot", 32'(data_b <= 8'h80), 32'd1);
            prev = int'(data_b);
            npop++;
         end
      end
      chk("lpf_converged", 32'(prev), 32'h80);
      chk("lpf_pop_count", 32'(npop >= 80), 32'd1);
      en_b = 1'b0; ready_b = 1'b0;

      // Overflow, clear, set-wins and full simultaneous push/pop.
      en_a = 1'b1; ready_a = 1'b0; clr_a = 1'b0;
      do_reset();
      run_until(16);
      chk("full_level", 32'(level_a), 32'd16);
      chk("full_no_overflow", 32'(ovf_a), 32'd0);
      chk("full_head", 32'(data_a), 32'(q[0]));
      run_until(17);
      chk("ovf_set", 32'(ovf_a), 32'd1);
      chk("ovf_level", 32'(level_a), 32'd16);
      chk("ovf_head_kept", 32'(data_a), 32'(q[0]));
      clr_a = 1'b1; step_a(); clr_a = 1'b0;
      chk("ovf_cleared", 32'(ovf_a), 32'd0);
      to_tick_cycle();
      clr_a = 1'b1; step_a(); clr_a = 1'b0;
      chk("ovf_set_wins", 32'(ovf_a), 32'd1);
      clr_a = 1'b1; step_a(); clr_a = 1'b0;
      chk("ovf_recleared", 32'(ovf_a), 32'd0);
      to_tick_cycle();
      ready_a = 1'b1;
      step_a();
      en_a = 1'b0;
      chk("pushpop_level", 32'(level_a), 32'd16);
      chk("pushpop_no_overflow", 32'(ovf_a), 32'd0);
      for (int i = 0; i < 16; i++) begin
         chk("pop_order", 32'(data_a), 32'(q[0]));
         step_a();
      end
      chk("drained_valid", 32'(valid_a), 32'd0);
      chk("drained_level", 32'(level_a), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
